multi_led_calibrator: RTL and testbench
=======================================

# multi_led_calibrator

N-channel successor to the two-LED (RED/IR) front-end controller. On request it calibrates DC compensation and PGA gain for each LED channel in turn from min/max statistics of the ADC stream, then time-multiplexes the channels with the stored settings and streams tagged ADC samples to the filter chain. It sits between the sensor analog front end (LED drivers, DC DAC, PGA, ADC) and the downstream filter block.

## Interface
- N_CH, 2, number of LED channels (1..8)
- ADC_W, 8, ADC sample width
- DC_W, 7, DC compensation code width
- PGA_W, 4, PGA gain code width
- WIN, 500, samples per measurement window
- SLOT, 10, cycles per channel slot in operation (>=2)
- AVG_LO / AVG_HI, 110 / 140, DC lock band on window average
- CLIP_LO / CLIP_HI, 10 / 245, clipping limits
- DC_DN / DC_UP / DC_INIT, 4 / 3 / 127, DC step down, step up, start code
- MAX_ITER, 64, DC windows per channel before giving up
- CLK  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- ADC  in  ADC_W  sample, valid every cycle
- Find_setting  in  1  synchronous calibration (re)start, level
- LED_EN  out  N_CH  one-hot LED enable
- DC_Comp  out  DC_W  DC compensation code
- PGA_Gain  out  PGA_W  gain code
- CLK_Filter  out  1  CLK/2 for filter block
- Value_out  out  ADC_W  sample in operation
- Value_ch  out  clog2(N_CH) max 1  channel tag of Value_out
- Value_valid  out  1  Value_out/Value_ch qualifier
- Busy / Done  out  1  calibrating / calibration finished, operating
- Cal_error  out  N_CH  per-channel calibration failure, sticky until restart

## Operation
- Reset: state IDLE; LED_EN=0, DC_Comp=DC_INIT, PGA_Gain=0, CLK_Filter=0, Value_*=0, Busy=Done=0, Cal_error=0, stored settings 0.
- CLK_Filter toggles every cycle from reset, independent of state.
- Find_setting=1 in any state: ch=0, Cal_error=0, Done=0, Busy=1, DC_Comp=DC_INIT, PGA_Gain=0, window cleared, iteration count 0, state DC_CAL. Held high, restart repeats every cycle.
- Window: WIN sample cycles track min/max of ADC; next cycle is the evaluate cycle (no sample taken), counter resets. avg=(max+min)>>1, computed ADC_W+1 bits wide.
- DC_CAL (LED_EN=1<<ch): avg<AVG_LO -> DC_Comp-=DC_DN saturating at 0; avg>AVG_HI -> DC_Comp+=DC_UP saturating at 2^DC_W-1; else store dc[ch], PGA_Gain=0, go PGA_CAL. On MAX_ITER-th unlocked evaluation: Cal_error[ch]=1, store current DC, go PGA_CAL.
- PGA_CAL: clipped if min<=CLIP_LO or max>=CLIP_HI. Not clipped and gain<max -> gain+1, stay. Not clipped at max gain -> store max. Clipped -> store gain-1; at gain 0 store 0 and set Cal_error[ch]. After storing: if ch<N_CH-1 then ch+1, DC_Comp=DC_INIT, PGA_Gain=0, DC_CAL; else OPERATION, Busy=0, Done=1.
- OPERATION: slot k active for SLOT cycles, LED_EN=1<<k, DC_Comp=dc[k], PGA_Gain=pga[k], all updated on the same edge. Slot cycle 0 is settle (no sample); cycles 1..SLOT-1 sample ADC. After slot N_CH-1 wraps to 0. N_CH=1: LED_EN constant.

## Timing
- All outputs registered. LED_EN for ch 0 asserted one edge after Find_setting sampled high.
- Each window spans WIN+1 cycles; settings change on edge after evaluate cycle.
- Value_valid/Value_out/Value_ch registered one cycle after the ADC sample; exactly SLOT-1 valid pulses per slot.
- Find_setting during OPERATION: Value_valid low from next edge.

## Structure
- Package led_cal_pkg: state enum (IDLE, DC_CAL, PGA_CAL, OPERATION), default threshold constants, saturating add/sub functions.
- Sub-module window_minmax: sample counter, min/max, avg, one-cycle eval pulse, synchronous clear.
- Stored dc/pga as N_CH-entry register arrays.

## Test plan
- N_CH=2, WIN=4, ADC constant 125: both DC lock first window, gain climbs to 15 with no clip, Done=1 after 2×(5+16×5) cycles, stored pga=15.
- ADC model avg 200 at DC_INIT=124, falling 10/code: DC_Comp steps +3 until avg in 110..140, then PGA_CAL.
- ADC swing scales with gain, clips at gain 6 -> stored pga=5; clip at gain 0 -> pga=0, Cal_error set.
- ADC stuck 0 with DC_Comp at 0: saturates at 0, Cal_error[ch]=1 after MAX_ITER windows, next channel proceeds.
- N_CH=3, SLOT=4 operation: LED_EN 001,010,100 repeating; 3 valid samples per slot tagged 0,1,2; DC/PGA match stored values.
- Find_setting pulse mid-OPERATION and rst mid-PGA_CAL: restart to DC_CAL ch 0 / all reset values immediately.

Source files
------------

// File: rtl/led_cal_pkg.sv
// Shared state encoding, default thresholds and saturating arithmetic for the
// multi-channel LED calibrator.
package led_cal_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DC_CAL,
        PGA_CAL,
        OPERATION
    } cal_state_e;

    localparam int unsigned DEF_AVG_LO   = 110;
    localparam int unsigned DEF_AVG_HI   = 140;
    localparam int unsigned DEF_CLIP_LO  = 10;
    localparam int unsigned DEF_CLIP_HI  = 245;
    localparam int unsigned DEF_DC_DN    = 4;
    localparam int unsigned DEF_DC_UP    = 3;
    localparam int unsigned DEF_DC_INIT  = 127;
    localparam int unsigned DEF_MAX_ITER = 64;

    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                            input int unsigned lim);
        return (a + b > lim) ? lim : a + b;
    endfunction

    function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
        return (a > b) ? a - b : 32'd0;
    endfunction

endpackage

// File: rtl/multi_led_calibrator_window.sv
// Measurement window: WIN sample cycles of min/max tracking, then one
// evaluate cycle in which min/max/avg are presented and the counter restarts.
module window_minmax #(
    parameter int unsigned ADC_W = 8,
    parameter int unsigned WIN   = 500
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [ADC_W-1:0] ADC,
    output logic             eval_c,
    output logic [ADC_W-1:0] min_val,
    output logic [ADC_W-1:0] max_val,
    output logic [ADC_W:0]   avg_c
);

    localparam int unsigned CNT_W = $clog2(WIN + 1);

    logic [CNT_W-1:0] cnt;

    assign eval_c = en && (cnt == CNT_W'(WIN));
    assign avg_c  = ((ADC_W + 1)'(min_val) + (ADC_W + 1)'(max_val)) >> 1;

    // First sample of a window seeds min/max so no sentinel values are needed
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            min_val <= '0;
            max_val <= '0;
        end else if (clr) begin
            cnt     <= '0;
            min_val <= '0;
            max_val <= '0;
        end else if (en) begin
            if (eval_c) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
                if (cnt == '0) begin
                    min_val <= ADC;
                    max_val <= ADC;
                end else begin
                    if (ADC < min_val) min_val <= ADC;
                    if (ADC > max_val) max_val <= ADC;
                end
            end
        end
    end

endmodule

// File: rtl/multi_led_calibrator.sv
// N-channel LED front-end controller: per-channel DC/PGA calibration from
// window statistics, then time-multiplexed operation streaming tagged samples.
module multi_led_calibrator
    import led_cal_pkg::*;
#(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned ADC_W    = 8,
    parameter int unsigned DC_W     = 7,
    parameter int unsigned PGA_W    = 4,
    parameter int unsigned WIN      = 500,
    parameter int unsigned SLOT     = 10,
    parameter int unsigned AVG_LO   = DEF_AVG_LO,
    parameter int unsigned AVG_HI   = DEF_AVG_HI,
    parameter int unsigned CLIP_LO  = DEF_CLIP_LO,
    parameter int unsigned CLIP_HI  = DEF_CLIP_HI,
    parameter int unsigned DC_DN    = DEF_DC_DN,
    parameter int unsigned DC_UP    = DEF_DC_UP,
    parameter int unsigned DC_INIT  = DEF_DC_INIT,
    parameter int unsigned MAX_ITER = DEF_MAX_ITER
) (
    input  logic                                          CLK,
    input  logic                                          rst,
    input  logic [ADC_W-1:0]                              ADC,
    input  logic                                          Find_setting,
    output logic [N_CH-1:0]                               LED_EN,
    output logic [DC_W-1:0]                               DC_Comp,
    output logic [PGA_W-1:0]                              PGA_Gain,
    output logic                                          CLK_Filter,
    output logic [ADC_W-1:0]                              Value_out,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]    Value_ch,
    output logic                                          Value_valid,
    output logic                                          Busy,
    output logic                                          Done,
    output logic [N_CH-1:0]                               Cal_error
);

    localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned SC_W    = $clog2(SLOT);
    localparam int unsigned IT_W    = $clog2(MAX_ITER + 1);
    localparam int unsigned DC_MAX  = (2 ** DC_W) - 1;
    localparam int unsigned PGA_MAX = (2 ** PGA_W) - 1;

    cal_state_e        state;
    logic [CH_W-1:0]   ch;
    logic [IT_W-1:0]   iter;
    logic [CH_W-1:0]   slot;
    logic [SC_W-1:0]   scnt;
    logic [DC_W-1:0]   dc_q  [N_CH];
    logic [PGA_W-1:0]  pga_q [N_CH];

    logic              win_en;
    logic              eval_c;
    logic [ADC_W-1:0]  min_val;
    logic [ADC_W-1:0]  max_val;
    logic [ADC_W:0]    avg_c;

    assign win_en = (state == DC_CAL) || (state == PGA_CAL);

    window_minmax #(
        .ADC_W (ADC_W),
        .WIN   (WIN)
    ) u_window (
        .CLK     (CLK),
        .rst     (rst),
        .clr     (Find_setting),
        .en      (win_en),
        .ADC     (ADC),
        .eval_c  (eval_c),
        .min_val (min_val),
        .max_val (max_val),
        .avg_c   (avg_c)
    );

    logic              dc_low_c;
    logic              dc_lock_c;
    logic              clip_c;
    logic              pga_done_c;
    logic              pga_err_c;
    logic [PGA_W-1:0]  pga_new_c;
    logic              last_ch_c;
    logic [CH_W-1:0]   slot_nxt_c;

    // Evaluate-cycle decisions and the next operating slot
    always_comb begin
        dc_low_c   = avg_c < (ADC_W + 1)'(AVG_LO);
        dc_lock_c  = !dc_low_c && (avg_c <= (ADC_W + 1)'(AVG_HI));
        clip_c     = (min_val <= ADC_W'(CLIP_LO)) || (max_val >= ADC_W'(CLIP_HI));
        pga_done_c = clip_c || (PGA_Gain == PGA_W'(PGA_MAX));
        pga_err_c  = clip_c && (PGA_Gain == '0);
        pga_new_c  = '0;
        if (!clip_c) begin
            pga_new_c = PGA_W'(PGA_MAX);
        end else if (PGA_Gain != '0) begin
            pga_new_c = PGA_Gain - PGA_W'(1);
        end
        last_ch_c  = (ch == CH_W'(N_CH - 1));
        slot_nxt_c = (slot == CH_W'(N_CH - 1)) ? '0 : slot + CH_W'(1);
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ch          <= '0;
            iter        <= '0;
            slot        <= '0;
            scnt        <= '0;
            LED_EN      <= '0;
            DC_Comp     <= DC_W'(DC_INIT);
            PGA_Gain    <= '0;
            CLK_Filter  <= 1'b0;
            Value_out   <= '0;
            Value_ch    <= '0;
            Value_valid <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Cal_error   <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                dc_q[i]  <= '0;
                pga_q[i] <= '0;
            end
        end else begin
            CLK_Filter  <= ~CLK_Filter;
            Value_valid <= 1'b0;
            if (Find_setting) begin
                state     <= DC_CAL;
                ch        <= '0;
                iter      <= '0;
                slot      <= '0;
                scnt      <= '0;
                LED_EN    <= N_CH'(1);
                DC_Comp   <= DC_W'(DC_INIT);
                PGA_Gain  <= '0;
                Busy      <= 1'b1;
                Done      <= 1'b0;
                Cal_error <= '0;
            end else begin
                case (state)
                    DC_CAL: begin
                        if (eval_c) begin
                            if (dc_lock_c || (iter == IT_W'(MAX_ITER - 1))) begin
                                dc_q[ch] <= DC_Comp;
                                PGA_Gain <= '0;
                                state    <= PGA_CAL;
                                if (!dc_lock_c) Cal_error[ch] <= 1'b1;
                            end else begin
                                iter    <= iter + IT_W'(1);
                                DC_Comp <= dc_low_c
                                         ? DC_W'(sat_sub(32'(DC_Comp), DC_DN))
                                         : DC_W'(sat_add(32'(DC_Comp), DC_UP, DC_MAX));
                            end
                        end
                    end
                    PGA_CAL: begin
                        if (eval_c) begin
                            if (!pga_done_c) begin
                                PGA_Gain <= PGA_Gain + PGA_W'(1);
                            end else begin
                                pga_q[ch] <= pga_new_c;
                                if (pga_err_c) Cal_error[ch] <= 1'b1;
                                if (last_ch_c) begin
                                    // Enter operation directly in slot 0
                                    state    <= OPERATION;
                                    Busy     <= 1'b0;
                                    Done     <= 1'b1;
                                    slot     <= '0;
                                    scnt     <= '0;
                                    LED_EN   <= N_CH'(1);
                                    DC_Comp  <= dc_q[0];
                                    PGA_Gain <= (N_CH == 1) ? pga_new_c : pga_q[0];
                                end else begin
                                    state    <= DC_CAL;
                                    ch       <= ch + CH_W'(1);
                                    iter     <= '0;
                                    LED_EN   <= N_CH'(1) << (ch + CH_W'(1));
                                    DC_Comp  <= DC_W'(DC_INIT);
                                    PGA_Gain <= '0;
                                end
                            end
                        end
                    end
                    OPERATION: begin
                        // Slot cycle 0 lets the analog path settle; the rest are sampled
                        if (scnt != '0) begin
                            Value_valid <= 1'b1;
                            Value_out   <= ADC;
                            Value_ch    <= slot;
                        end
                        if (scnt == SC_W'(SLOT - 1)) begin
                            scnt     <= '0;
                            slot     <= slot_nxt_c;
                            LED_EN   <= N_CH'(1) << slot_nxt_c;
                            DC_Comp  <= dc_q[slot_nxt_c];
                            PGA_Gain <= pga_q[slot_nxt_c];
                        end else begin
                            scnt <= scnt + SC_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multi_led_calibrator.sv
// Bench for multi_led_calibrator: a sensor model drives ADC from the DUT's
// LED/DC/PGA outputs, and a behavioural calibration model predicts results.
module tb_multi_led_calibrator;

    localparam int unsigned N_CH     = 3;
    localparam int unsigned CH_W     = 2;
    localparam int unsigned WIN      = 4;
    localparam int unsigned SLOT     = 4;
    localparam int unsigned MAX_ITER = 8;
    localparam int unsigned DC_INIT  = 100;
    localparam int AVG_LO  = 110;
    localparam int AVG_HI  = 140;
    localparam int CLIP_LO = 10;
    localparam int CLIP_HI = 245;
    localparam int DC_DN   = 4;
    localparam int DC_UP   = 3;
    localparam int DC_TOP  = 127;
    localparam int PGA_TOP = 15;

    logic            CLK = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      ADC = 8'd0;
    logic            Find_setting = 1'b0;
    logic [N_CH-1:0] LED_EN;
    logic [6:0]      DC_Comp;
    logic [3:0]      PGA_Gain;
    logic            CLK_Filter;
    logic [7:0]      Value_out;
    logic [CH_W-1:0] Value_ch;
    logic            Value_valid;
    logic            Busy;
    logic            Done;
    logic [N_CH-1:0] Cal_error;

    int n_checks = 0;
    int n_pass   = 0;

    int base [N_CH];
    int amp  [N_CH];
    bit stuck[N_CH];
    int exp_dc [N_CH];
    int exp_pga[N_CH];
    logic [N_CH-1:0] exp_err;
    int exp_windows;
    bit op_rand = 1'b0;
    bit phase   = 1'b0;

    multi_led_calibrator #(
        .N_CH     (N_CH),
        .ADC_W    (8),
        .DC_W     (7),
        .PGA_W    (4),
        .WIN      (WIN),
        .SLOT     (SLOT),
        .MAX_ITER (MAX_ITER),
        .DC_INIT  (DC_INIT)
    ) dut (
        .CLK          (CLK),
        .rst          (rst),
        .ADC          (ADC),
        .Find_setting (Find_setting),
        .LED_EN       (LED_EN),
        .DC_Comp      (DC_Comp),
        .PGA_Gain     (PGA_Gain),
        .CLK_Filter   (CLK_Filter),
        .Value_out    (Value_out),
        .Value_ch     (Value_ch),
        .Value_valid  (Value_valid),
        .Busy         (Busy),
        .Done         (Done),
        .Cal_error    (Cal_error)
    );

    always #5 CLK = ~CLK;

    function automatic int clamp8(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    // Sensor: higher DC code pulls the level down 10 LSB/code; swing grows with gain
    function automatic int center_of(input int c, input int dc);
        return stuck[c] ? 0 : clamp8(base[c] - 10 * (dc - int'(DC_INIT)));
    endfunction

    function automatic int swing_of(input int c, input int g);
        return amp[c] * (g + 1);
    endfunction

    function automatic int led_index(input logic [N_CH-1:0] led);
        int idx = 0;
        for (int i = 0; i < int'(N_CH); i++) if (led[i]) idx = i;
        return idx;
    endfunction

    always @(negedge CLK) begin : sensor
        int c;
        int v;
        phase = ~phase;
        if (op_rand) begin
            ADC = 8'($urandom_range(0, 255));
        end else begin
            c = led_index(LED_EN);
            v = center_of(c, int'(DC_Comp)) + (phase ? 1 : -1) * swing_of(c, int'(PGA_Gain));
            ADC = 8'(clamp8(v));
        end
    end

    // Expected per-channel outcome of calibration and the number of windows it takes
    function automatic void run_model();
        exp_windows = 0;
        exp_err     = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            int dc;
            int mn;
            int mx;
            int avg;
            dc = int'(DC_INIT);
            for (int it = 0; it < int'(MAX_ITER); it++) begin
                exp_windows++;
                mn  = clamp8(center_of(c, dc) - swing_of(c, 0));
                mx  = clamp8(center_of(c, dc) + swing_of(c, 0));
                avg = (mn + mx) / 2;
                if (avg >= AVG_LO && avg <= AVG_HI) break;
                if (it == int'(MAX_ITER) - 1) begin
                    exp_err[c] = 1'b1;
                    break;
                end
                if (avg < AVG_LO) dc = (dc - DC_DN < 0) ? 0 : dc - DC_DN;
                else              dc = (dc + DC_UP > DC_TOP) ? DC_TOP : dc + DC_UP;
            end
            exp_dc[c] = dc;
            for (int g = 0; g <= PGA_TOP; g++) begin
                exp_windows++;
                mn = clamp8(center_of(c, dc) - swing_of(c, g));
                mx = clamp8(center_of(c, dc) + swing_of(c, g));
                if (mn <= CLIP_LO || mx >= CLIP_HI) begin
                    if (g == 0) begin
                        exp_pga[c] = 0;
                        exp_err[c] = 1'b1;
                    end else begin
                        exp_pga[c] = g - 1;
                    end
                    break;
                end
                if (g == PGA_TOP) exp_pga[c] = PGA_TOP;
            end
        end
    endfunction

    task automatic test_reset();
        logic prev;
        repeat (2) @(negedge CLK);
        n_checks++; if (LED_EN !== 3'b000) $display("FAIL reset_led_en: got %b want 000", LED_EN); else n_pass++;
        n_checks++; if (DC_Comp !== 7'(DC_INIT)) $display("FAIL reset_dc: got %0d want %0d", DC_Comp, DC_INIT); else n_pass++;
        n_checks++; if (PGA_Gain !== 4'd0) $display("FAIL reset_pga: got %0d want 0", PGA_Gain); else n_pass++;
        n_checks++; if (CLK_Filter !== 1'b0) $display("FAIL reset_clk_filter: got %b want 0", CLK_Filter); else n_pass++;
        n_checks++; if ({Value_valid, Value_out, Value_ch} !== 11'd0) $display("FAIL reset_value: got %b/%0d/%0d want 0", Value_valid, Value_out, Value_ch); else n_pass++;
        n_checks++; if ({Busy, Done, Cal_error} !== 5'd0) $display("FAIL reset_status: got %b%b/%b want 00/000", Busy, Done, Cal_error); else n_pass++;
        rst = 1'b0;
        prev = CLK_Filter;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK); #1;
            n_checks++; if (CLK_Filter !== ~prev) $display("FAIL clk_filter_toggle: got %b want %b", CLK_Filter, ~prev); else n_pass++;
            prev = CLK_Filter;
        end
        n_checks++; if ({LED_EN, Busy, Done} !== 5'd0) $display("FAIL idle_hold: got %b%b%b want 00000", LED_EN, Busy, Done); else n_pass++;
    endtask

    // Hold Find_setting for len edges, check the restart state, then wait for Done
    task automatic run_cal(input string name, input int len);
        int  cyc;
        bit  got;
        run_model();
        op_rand = 1'b0;
        @(negedge CLK);
        Find_setting = 1'b1;
        repeat (len) @(posedge CLK);
        #1;
        n_checks++; if (LED_EN !== 3'b001) $display("FAIL %s_start_led: got %b want 001", name, LED_EN); else n_pass++;
        n_checks++; if ({Busy, Done} !== 2'b10) $display("FAIL %s_start_busy: got %b%b want 10", name, Busy, Done); else n_pass++;
        n_checks++; if ({DC_Comp, PGA_Gain} !== {7'(DC_INIT), 4'd0}) $display("FAIL %s_start_codes: got %0d/%0d want %0d/0", name, DC_Comp, PGA_Gain, DC_INIT); else n_pass++;
        n_checks++; if ({Cal_error, Value_valid} !== 4'd0) $display("FAIL %s_start_flags: got %b/%b want 000/0", name, Cal_error, Value_valid); else n_pass++;
        @(negedge CLK);
        Find_setting = 1'b0;
        got = 1'b0;
        cyc = 0;
        for (int n = 1; n <= 2000; n++) begin
            @(posedge CLK); #1;
            if (Done === 1'b1) begin
                got = 1'b1;
                cyc = n;
                break;
            end
        end
        n_checks++; if (!got) $display("FAIL %s_done_timeout: got no Done want Done within 2000 cycles", name); else n_pass++;
        n_checks++; if (cyc != exp_windows * int'(WIN + 1)) $display("FAIL %s_done_cycle: got %0d want %0d", name, cyc, exp_windows * int'(WIN + 1)); else n_pass++;
        n_checks++; if (Busy !== 1'b0) $display("FAIL %s_busy_clear: got %b want 0", name, Busy); else n_pass++;
        n_checks++; if (Cal_error !== exp_err) $display("FAIL %s_cal_error: got %b want %b", name, Cal_error, exp_err); else n_pass++;
    endtask

    // Called right after the Done edge: walk two full channel rounds
    task automatic test_operation(input string name);
        int   cur;
        int   p;
        int   nvalid;
        logic a;
        logic [7:0] smp;
        logic prev_cf;
        bit   ev;
        nvalid = 0;
        op_rand = 1'b1;
        prev_cf = CLK_Filter;
        for (int j = 0; j <= 2 * int'(N_CH * SLOT); j++) begin
            if (j > 0) begin
                @(posedge CLK);
                smp = ADC;
                #1;
                n_checks++; if (CLK_Filter !== ~prev_cf) $display("FAIL %s_op_clk_filter: got %b want %b", name, CLK_Filter, ~prev_cf); else n_pass++;
                prev_cf = CLK_Filter;
                p  = j - 1;
                ev = (p % int'(SLOT)) != 0;
                n_checks++; if (Value_valid !== ev) $display("FAIL %s_op_valid j=%0d: got %b want %b", name, j, Value_valid, ev); else n_pass++;
                if (ev) begin
                    nvalid++;
                    n_checks++; if (Value_out !== smp) $display("FAIL %s_op_value j=%0d: got %0d want %0d", name, j, Value_out, smp); else n_pass++;
                    n_checks++; if (Value_ch !== CH_W'((p / int'(SLOT)) % int'(N_CH))) $display("FAIL %s_op_tag j=%0d: got %0d want %0d", name, j, Value_ch, (p / int'(SLOT)) % int'(N_CH)); else n_pass++;
                end
            end
            cur = (j / int'(SLOT)) % int'(N_CH);
            n_checks++; if (LED_EN !== N_CH'(1) << cur) $display("FAIL %s_op_led j=%0d: got %b want %b", name, j, LED_EN, N_CH'(1) << cur); else n_pass++;
            n_checks++; if (DC_Comp !== 7'(exp_dc[cur])) $display("FAIL %s_op_dc j=%0d: got %0d want %0d", name, j, DC_Comp, exp_dc[cur]); else n_pass++;
            n_checks++; if (PGA_Gain !== 4'(exp_pga[cur])) $display("FAIL %s_op_pga j=%0d: got %0d want %0d", name, j, PGA_Gain, exp_pga[cur]); else n_pass++;
        end
        a = 1'b0;
        n_checks++; if (nvalid != 2 * int'(N_CH * (SLOT - 1))) $display("FAIL %s_op_pulse_count: got %0d want %0d", name, nvalid, 2 * (N_CH * (SLOT - 1))); else n_pass++;
        n_checks++; if ({Done, Busy, a} !== 3'b100) $display("FAIL %s_op_status: got %b%b want 10", name, Done, Busy); else n_pass++;
    endtask

    task automatic test_back_to_back_restart();
        // Restart from operation reuses the same sensor, so results must repeat
        run_cal("restart", 1);
        test_operation("restart");
    endtask

    task automatic test_rst_mid_cal();
        bit reached;
        for (int c = 0; c < int'(N_CH); c++) begin
            base[c] = 125; amp[c] = 0; stuck[c] = 1'b0;
        end
        op_rand = 1'b0;
        @(negedge CLK); Find_setting = 1'b1;
        @(negedge CLK); Find_setting = 1'b0;
        reached = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge CLK); #1;
            if (PGA_Gain >= 4'd3) begin
                reached = 1'b1;
                break;
            end
        end
        n_checks++; if (!reached) $display("FAIL rst_mid_reach_pga: got gain %0d want >=3 within 200 cycles", PGA_Gain); else n_pass++;
        @(negedge CLK); #2;
        rst = 1'b1;
        #1;
        n_checks++; if ({LED_EN, PGA_Gain, Busy, Done} !== 9'd0) $display("FAIL rst_mid_outputs: got %b/%0d/%b%b want 000/0/00", LED_EN, PGA_Gain, Busy, Done); else n_pass++;
        n_checks++; if ({DC_Comp, CLK_Filter} !== {7'(DC_INIT), 1'b0}) $display("FAIL rst_mid_dc: got %0d/%b want %0d/0", DC_Comp, CLK_Filter, DC_INIT); else n_pass++;
        @(negedge CLK); rst = 1'b0;
        repeat (12) @(posedge CLK);
        #1;
        n_checks++; if ({LED_EN, Busy, Done, Value_valid} !== 6'd0) $display("FAIL rst_mid_idle: got %b%b%b%b want 000000", LED_EN, Busy, Done, Value_valid); else n_pass++;
    endtask

    initial begin
        test_reset();

        for (int c = 0; c < int'(N_CH); c++) begin
            base[c] = 125; amp[c] = 0; stuck[c] = 1'b0;
        end
        run_cal("const", 1);
        test_operation("const");

        base[0] = 200; amp[0] = 0;
        base[1] = 125; amp[1] = 18;
        base[2] = 125; amp[2] = 120;
        run_cal("step_clip", 1);
        test_operation("step_clip");

        stuck[0] = 1'b1; amp[0] = 0;
        base[1] = 125; amp[1] = 5;
        base[2] = 150; amp[2] = 0;
        run_cal("stuck", 2);
        test_operation("stuck");

        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < int'(N_CH); c++) begin
                base[c]  = int'($urandom_range(60, 230));
                stuck[c] = ($urandom_range(0, 5) == 0);
                amp[c]   = stuck[c] ? 0 : int'($urandom_range(0, 25));
            end
            run_cal($sformatf("rand%0d", r), int'($urandom_range(1, 3)));
            test_operation($sformatf("rand%0d", r));
        end

        test_back_to_back_restart();
        test_rst_mid_cal();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
